debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//   Parametrised multi-channel successor to the single-button debouncer. Synchronises N_CH raw
//   button/switch inputs, debounces them against a shared prescaled tick, and emits clean levels,
//   one-cycle press/release pulses and optional per-channel auto-repeat pulses. Sits between the
//   labkit pins and the key_num / note-trigger logic feeding the visual and audio modules.
// PARAMETERS
//   N_CH                 17     number of independent channels
//   ACTIVE_LOW           1      1: input low = pressed (inverted after sync); 0: input high = pressed
//   SYNC_STAGES          2      synchroniser flops per channel (>=2)
//   TICK_DIV             650    clock cycles per debounce tick (10 us at 65 MHz)
//   STABLE_TICKS         1000   ticks a new level must hold before clean follows (10 ms)
//   REPEAT_DELAY_TICKS   50000  ticks from press to first repeat pulse (0.5 s)
//   REPEAT_PERIOD_TICKS  10000  ticks between subsequent repeat pulses (0.1 s)
// PORTS
//   clock      in   1     system clock (clock_65mhz in the top level)
//   reset      in   1     asynchronous, active-high reset
//   noisy      in   N_CH  raw asynchronous inputs, polarity per ACTIVE_LOW
//   repeat_en  in   N_CH  per-channel auto-repeat enable (synchronous to clock)
//   clean      out  N_CH  debounced level, 1 = pressed
//   press      out  N_CH  1-cycle pulse on clean 0->1
//   release    out  N_CH  1-cycle pulse on clean 1->0
//   repeat     out  N_CH  1-cycle auto-repeat pulse while held
//   any_change out  1     OR of press|release, same cycle
// BEHAVIOUR
//   Reset (async, active-high): every flop is cleared immediately. clean, press, release, repeat
//   and any_change go to 0. Sync flops load the released level. The prescaler and all counters
//   go to 0. Repeat FSMs go to IDLE.
//   Sync: noisy passes through SYNC_STAGES flops and is then inverted if ACTIVE_LOW, giving s[i].
//   Prescaler: counts 0..TICK_DIV-1 and wraps to 0. tick = 1 for the one cycle where
//   count == TICK_DIV-1. The prescaler is shared by all channels.
//   Debounce, per channel:
//     - s==clean: cnt <= 0.
//     - else on tick: if cnt==STABLE_TICKS-1 then clean <= s and cnt <= 0; otherwise cnt++.
//     - Any return of s to clean before then clears cnt, so a glitch never propagates.
//     - Latency from a stable s change to clean: (STABLE_TICKS-1)*TICK_DIV+1 to
//       STABLE_TICKS*TICK_DIV cycles, plus SYNC_STAGES.
//   Edges: press/release are registered and asserted in the cycle after clean changes, for
//   exactly 1 cycle. any_change follows the same timing.
//   Repeat FSM, per channel, states IDLE/DELAY/RPT, rcnt counts on tick only:
//     - IDLE->DELAY on press if repeat_en, with rcnt <= 0.
//     - DELAY, on tick: rcnt==REPEAT_DELAY_TICKS-1 -> pulse repeat, go to RPT, rcnt <= 0;
//       else rcnt++.
//     - RPT, on tick: rcnt==REPEAT_PERIOD_TICKS-1 -> pulse repeat, rcnt <= 0; else rcnt++.
//     - Any state -> IDLE when clean==0 or repeat_en==0. This takes priority over a pulse in the
//       same cycle.
//     - repeat never coincides with press. Asserting repeat_en while already held does not start
//       repeat; a new press is needed.
//   Widths: cnt and rcnt are sized with a constant log2 function. Counters saturate at their
//   terminal compare and never wrap past it.
//   Channels are fully independent. Simultaneous events on different channels all pulse in the
//   same cycle.
// TESTING
//   Bench parameters: N_CH=4, ACTIVE_LOW=1, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY_TICKS=5,
//   REPEAT_PERIOD_TICKS=2.
//   1. Reset with noisy=4'hF, then release reset
//      -> all outputs 0 and stay 0 for 200 cycles; no pulses.
//   2. noisy[1] toggles every 5 cycles for 200 cycles
//      -> clean[1]=0 throughout; press[1]/release[1] never assert.
//   3. noisy[0] low and held
//      -> clean[0]=1 within 11..14 cycles; press[0] exactly 1 cycle.
//      noisy[0] high and held -> clean[0]=0 after the same window; release[0] exactly 1 cycle.
//   4. repeat_en[2]=1, hold ch2
//      -> first repeat[2] 20+/-4 cycles after press[2], then every 8 cycles.
//      Drop repeat_en[2] -> no further repeat.
//      Release ch2 -> no repeat after release[2].
//   5. ch0 pressed and ch3 released aligned to the same tick
//      -> press[0] and release[3] in the same cycle; any_change=1 for that one cycle.
//   6. Assert reset mid-RPT on ch2
//      -> clean, repeat and all outputs 0 the same cycle, without waiting for an edge.
//      After release, the held input re-debounces and gives a fresh press[2].

Source files
------------

// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Multi-channel button/switch conditioner. Each raw input is synchronised,
//   debounced against a shared prescaled tick, and turned into a clean level,
//   one-cycle press/release pulses and an optional auto-repeat pulse train.
//
// Ports
//   clock_i       system clock
//   reset_i       asynchronous active-high reset, clears every flop at once
//   noisy_i       raw asynchronous inputs (low = pressed when ACTIVE_LOW=1)
//   repeat_en_i   per-channel auto-repeat enable, synchronous to clock_i
//   clean_o       debounced level, 1 = pressed
//   press_o       1-cycle pulse, the cycle after clean_o rises
//   release_o     1-cycle pulse, the cycle after clean_o falls
//   repeat_o      1-cycle auto-repeat pulse while a channel stays held
//   any_change_o  OR of all press/release pulses, same cycle
// ---------------------------------------------------------------------------
module debounce_bank #(
    parameter int N_CH                = 17,
    parameter int ACTIVE_LOW          = 1,
    parameter int SYNC_STAGES         = 2,
    parameter int TICK_DIV            = 650,
    parameter int STABLE_TICKS        = 1000,
    parameter int REPEAT_DELAY_TICKS  = 50000,
    parameter int REPEAT_PERIOD_TICKS = 10000
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] noisy_i,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            any_change_o
);

    // Bits needed to hold 0..value-1 (at least one bit).
    function automatic int clog2w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                             REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
    localparam int PRE_W   = clog2w(TICK_DIV);
    localparam int CNT_W   = clog2w(STABLE_TICKS);
    localparam int RCNT_W  = clog2w(RPT_MAX);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [RCNT_W-1:0] DLY_LAST = RCNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RCNT_W-1:0] PER_LAST = RCNT_W'(REPEAT_PERIOD_TICKS - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);

    // Raw level that means "released", so the synchroniser wakes up idle.
    localparam logic [N_CH-1:0] SYNC_RST = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_DELAY = 2'd1,
        RS_RPT   = 2'd2
    } rstate_t;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s_s;

    logic [PRE_W-1:0]                 presc_q;
    logic [PRE_W-1:0]                 presc_d;
    logic                             tick_s;

    logic [N_CH-1:0][CNT_W-1:0]       cnt_q;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_d;
    logic [N_CH-1:0]                  clean_q;
    logic [N_CH-1:0]                  clean_d;
    logic [N_CH-1:0]                  clean_dly_q;

    logic [N_CH-1:0]                  press_q;
    logic [N_CH-1:0]                  press_d;
    logic [N_CH-1:0]                  release_q;
    logic [N_CH-1:0]                  release_d;
    logic                             any_q;
    logic                             any_d;

    rstate_t [N_CH-1:0]               rstate_q;
    rstate_t [N_CH-1:0]               rstate_d;
    logic [N_CH-1:0][RCNT_W-1:0]      rcnt_q;
    logic [N_CH-1:0][RCNT_W-1:0]      rcnt_d;
    logic [N_CH-1:0]                  repeat_q;
    logic [N_CH-1:0]                  repeat_d;

    // Synchroniser shift chain; the oldest stage is the usable sample.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy_i};
        end
    end

    // Normalise polarity so that 1 always means pressed downstream.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            s_s = ~sync_q[SYNC_STAGES-1];
        end else begin
            s_s = sync_q[SYNC_STAGES-1];
        end
    end

    // Shared prescaler next state and tick strobe.
    always_comb begin
        tick_s = (presc_q == PRE_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRE_ONE;
        end
    end

    // Prescaler register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Debounce next state: a differing level must survive STABLE_TICKS
    // consecutive ticks; any return to the clean level restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (s_s[ch] == clean_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (tick_s) begin
                if (cnt_q[ch] >= CNT_LAST) begin
                    clean_d[ch] = s_s[ch];
                    cnt_d[ch]   = '0;
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                end
            end else begin
                cnt_d[ch] = cnt_q[ch];
            end
        end
    end

    // Debounce counters, clean levels and the one-cycle-delayed copy used
    // for edge detection.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            clean_q     <= '0;
            clean_dly_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_q;
        end
    end

    // Edge pulses: compare clean with its previous value, so the pulse
    // lands in the cycle after clean changes.
    always_comb begin
        press_d   = clean_q & ~clean_dly_q;
        release_d = ~clean_q & clean_dly_q;
        any_d     = |(press_d | release_d);
    end

    // Registered edge pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= any_d;
        end
    end

    // Repeat FSMs. Dropping clean or repeat_en forces IDLE and wins over a
    // pulse due in the same cycle. Arming only happens on the press pulse,
    // so enabling repeat on an already-held key does nothing until re-press.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        repeat_d = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (!clean_q[ch] || !repeat_en_i[ch]) begin
                rstate_d[ch] = RS_IDLE;
                rcnt_d[ch]   = '0;
            end else begin
                case (rstate_q[ch])
                    RS_IDLE: begin
                        if (press_q[ch]) begin
                            rstate_d[ch] = RS_DELAY;
                            rcnt_d[ch]   = '0;
                        end else begin
                            rstate_d[ch] = RS_IDLE;
                        end
                    end
                    RS_DELAY: begin
                        if (tick_s) begin
                            if (rcnt_q[ch] >= DLY_LAST) begin
                                repeat_d[ch] = 1'b1;
                                rstate_d[ch] = RS_RPT;
                                rcnt_d[ch]   = '0;
                            end else begin
                                rcnt_d[ch] = rcnt_q[ch] + RCNT_ONE;
                            end
                        end else begin
                            rcnt_d[ch] = rcnt_q[ch];
                        end
                    end
                    RS_RPT: begin
                        if (tick_s) begin
                            if (rcnt_q[ch] >= PER_LAST) begin
                                repeat_d[ch] = 1'b1;
                                rcnt_d[ch]   = '0;
                            end else begin
                                rcnt_d[ch] = rcnt_q[ch] + RCNT_ONE;
                            end
                        end else begin
                            rcnt_d[ch] = rcnt_q[ch];
                        end
                    end
                    default: begin
                        rstate_d[ch] = RS_IDLE;
                        rcnt_d[ch]   = '0;
                    end
                endcase
            end
        end
    end

    // Repeat state, tick counters and registered repeat pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rstate_q <= {N_CH{RS_IDLE}};
            rcnt_q   <= '0;
            repeat_q <= '0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign clean_o      = clean_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign repeat_o     = repeat_q;
    assign any_change_o = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RP = 2;
    localparam int SS = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] noisy;
    logic [N-1:0] en;
    logic [N-1:0] clean;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
    logic         any;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    debounce_bank #(
        .N_CH(N), .ACTIVE_LOW(1), .SYNC_STAGES(SS), .TICK_DIV(TD),
        .STABLE_TICKS(ST), .REPEAT_DELAY_TICKS(RD), .REPEAT_PERIOD_TICKS(RP)
    ) dut (
        .clock_i(clk), .reset_i(rst), .noisy_i(noisy), .repeat_en_i(en),
        .clean_o(clean), .press_o(press), .release_o(rel), .repeat_o(rep),
        .any_change_o(any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Timestamps and tick arithmetic: a level is accepted once it has differed
    // from clean across STABLE_TICKS tick cycles; repeat pulses fall on the
    // RD-th tick after arming and every RP ticks thereafter.
    logic [N-1:0] m_hist [SS];
    int           m_cyc;
    logic [N-1:0] m_clean, m_press, m_rel, m_rep, m_rose, m_fell;
    logic         m_any;
    int           m_dstart [N];
    bit           m_armed [N];
    int           m_arm [N];

    function automatic int ticks_upto(input int x);
        return (x + 1) / TD;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_hist[i] = '1;
        m_cyc = 0;
        m_clean = '0; m_press = '0; m_rel = '0; m_rep = '0;
        m_rose = '0; m_fell = '0; m_any = 1'b0;
        for (int c = 0; c < N; c++) begin
            m_dstart[c] = -1; m_armed[c] = 1'b0; m_arm[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [N-1:0] s, n_clean, n_rose, n_fell, n_rep;
        bit tick;
        int nt;
        s = ~m_hist[SS-1];
        tick = (m_cyc % TD) == TD - 1;
        n_clean = m_clean; n_rose = '0; n_fell = '0; n_rep = '0;
        for (int c = 0; c < N; c++) begin
            if (m_armed[c]) begin
                if (!m_clean[c] || !en[c]) m_armed[c] = 1'b0;
                else if (tick) begin
                    nt = ticks_upto(m_cyc) - ticks_upto(m_arm[c]);
                    if (nt == RD || (nt > RD && (nt - RD) % RP == 0)) n_rep[c] = 1'b1;
                end
            end else if (m_press[c] && en[c] && m_clean[c]) begin
                m_armed[c] = 1'b1;
                m_arm[c] = m_cyc;
            end
            if (s[c] == m_clean[c]) m_dstart[c] = -1;
            else begin
                if (m_dstart[c] < 0) m_dstart[c] = m_cyc;
                if (tick && (ticks_upto(m_cyc) - ticks_upto(m_dstart[c] - 1)) >= ST) begin
                    n_clean[c] = s[c];
                    n_rose[c] = s[c];
                    n_fell[c] = ~s[c];
                    m_dstart[c] = -1;
                end
            end
        end
        m_press = m_rose; m_rel = m_fell; m_any = |(m_rose | m_fell);
        m_rep = n_rep; m_clean = n_clean; m_rose = n_rose; m_fell = n_fell;
        for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = noisy;
        m_cyc++;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (chk_on)
            check("model", {15'd0, clean, press, rel, rep, any},
                  {15'd0, m_clean, m_press, m_rel, m_rep, m_any});
    end

    // ---------------- helpers ----------------
    function automatic logic sel(input int which, input int c);
        case (which)
            0: return press[c];
            1: return rel[c];
            2: return rep[c];
            3: return clean[c];
            4: return ~clean[c];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int c, input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (sel(which, c)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_hi(input int which, input int c, input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (sel(which, c)) cnt++;
        end
    endtask

    typedef struct {
        logic [3:0] noisy;
        int         hold;
        logic [3:0] exp_clean;
    } vec_t;

    vec_t vecs [8];
    int   n, c, c2;
    logic [16:0] seen;

    initial begin
        vecs[0] = '{4'hF, 20, 4'h0};
        vecs[1] = '{4'hE, 20, 4'h1};
        vecs[2] = '{4'hC, 20, 4'h3};
        vecs[3] = '{4'h0, 20, 4'hF};
        vecs[4] = '{4'h5, 20, 4'hA};
        vecs[5] = '{4'hF, 5,  4'hA};
        vecs[6] = '{4'h5, 20, 4'hA};
        vecs[7] = '{4'hF, 20, 4'h0};

        // 1: reset with all inputs released
        rst = 1'b1; noisy = 4'hF; en = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        seen = '0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            seen |= {clean, press, rel, rep, any};
        end
        check("idle_quiet", {15'd0, seen}, 32'd0);

        // table-driven level checks, including a too-short glitch
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            noisy = vecs[v].noisy;
            repeat (vecs[v].hold) @(negedge clk);
            check($sformatf("vec%0d_clean", v), {28'd0, clean}, {28'd0, vecs[v].exp_clean});
        end

        // 2: ch1 bounces every 5 cycles
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            noisy[1] = ~noisy[1];
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                seen[0] = seen[0] | clean[1] | press[1] | rel[1];
            end
        end
        check("bounce_ch1", {15'd0, seen}, 32'd0);
        repeat (20) @(negedge clk);

        // 3: press/release latency and pulse width on ch0
        @(negedge clk); noisy[0] = 1'b0;
        wait_for(3, 0, 30, n);
        check("press_latency_ok", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
        count_hi(0, 0, 6, c);
        check("press_width", c, 32'd1);
        @(negedge clk); noisy[0] = 1'b1;
        wait_for(4, 0, 30, n);
        check("release_latency_ok", {31'd0, (n >= 11 && n <= 14)}, 32'd1);
        count_hi(1, 0, 6, c);
        check("release_width", c, 32'd1);

        // 4: auto-repeat on ch2
        @(negedge clk); en[2] = 1'b1; noisy[2] = 1'b0;
        wait_for(0, 2, 30, n);
        check("ch2_press_seen", {31'd0, (n <= 30)}, 32'd1);
        wait_for(2, 2, 40, n);
        check("first_repeat_ok", {31'd0, (n >= 16 && n <= 24)}, 32'd1);
        wait_for(2, 2, 12, n);
        check("repeat_gap1", n, 32'd8);
        wait_for(2, 2, 12, n);
        check("repeat_gap2", n, 32'd8);
        @(negedge clk); en[2] = 1'b0;
        count_hi(2, 2, 40, c);
        check("no_repeat_en_off", c, 32'd0);
        @(negedge clk); en[2] = 1'b1;
        count_hi(2, 2, 40, c);
        check("no_rearm_while_held", c, 32'd0);
        @(negedge clk); noisy[2] = 1'b1;
        wait_for(1, 2, 30, n);
        @(negedge clk); noisy[2] = 1'b0;
        wait_for(2, 2, 60, n);
        wait_for(2, 2, 12, n);
        check("repeat_gap3", n, 32'd8);
        @(negedge clk); noisy[2] = 1'b1;
        wait_for(1, 2, 30, n);
        check("ch2_release_seen", {31'd0, (n <= 30)}, 32'd1);
        count_hi(2, 2, 40, c);
        check("no_repeat_after_release", c, 32'd0);

        // 5: simultaneous press on ch0 and release on ch3
        @(negedge clk); noisy[3] = 1'b0;
        repeat (20) @(negedge clk);
        noisy[0] = 1'b0; noisy[3] = 1'b1;
        wait_for(0, 0, 30, n);
        check("press0_seen", {31'd0, (n <= 30)}, 32'd1);
        check("release3_same_cycle", {31'd0, rel[3]}, 32'd1);
        check("any_change_on", {31'd0, any}, 32'd1);
        @(posedge clk); #1;
        check("any_change_off", {31'd0, any}, 32'd0);
        @(negedge clk); noisy[0] = 1'b1;
        repeat (20) @(negedge clk);

        // 6: async reset while ch2 is repeating
        en[2] = 1'b1; noisy[2] = 1'b0;
        wait_for(0, 2, 30, n);
        wait_for(2, 2, 40, n);
        wait_for(2, 2, 12, n);
        @(posedge clk); #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("reset_async_outputs", {15'd0, clean, press, rel, rep, any}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_for(0, 2, 40, n);
        check("fresh_press_after_reset", {31'd0, (n <= 40)}, 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(23) == 0) noisy[k] = ~noisy[k];
                if ($urandom_range(79) == 0) en[k] = ~en[k];
            end
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
